tc_register_file: RTL and testbench
===================================

Name: tc_register_file

Overview:
- Parametrised multi-entry successor to the single-word TC register: DEPTH words of DATA_W bits.
- Two independent read ports with output-enable semantics: data is zero when the port is not enabled.
- One write port.
- A multi-cycle clear sweep FSM zeroes the array without a global reset.
- Used as the general-purpose register bank in TC-style CPU datapaths.

Parameters:
- DATA_W, 8, word width in bits (>=1).
- DEPTH, 8, number of entries (>=2, need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd0_en  in  1  read port 0 enable.
- rd0_addr  in  ADDR_W  read port 0 address.
- rd0_data  out  DATA_W  read port 0 data, registered.
- rd1_en  in  1  read port 1 enable.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd1_data  out  DATA_W  read port 1 data, registered.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  start clear sweep (single-cycle pulse or level).
- busy  out  1  sweep in progress; writes are dropped while high.

Behaviour:
- Reset (reset is synchronous, active-high; clock is clk):
  - At the edge, all entries become 0; rd0_data/rd1_data become 0; busy becomes 0; FSM goes to IDLE; sweep pointer becomes 0.
  - Reset overrides every other input in that cycle.
- Read, latency 1:
  - At edge t: rdN_data <= rdN_en ? entry[rdN_addr] : 0.
  - The entry value used is the pre-write content of cycle t; write-through is governed by the optional feature.
  - Ports are fully independent; the same address on both ports is legal.
- Out-of-range access (addr >= DEPTH, only possible when DEPTH is not 2^n):
  - Read returns 0.
  - Write is dropped silently.
- Write:
  - Accepted when wr_en & !busy & !reset.
  - entry[wr_addr] <= wr_data at the edge; visible to reads issued in cycle t+1.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr_req=1 -> SWEEP, ptr <= 0, busy <= 1. A write presented in the same cycle is still accepted, because busy is low; the sweep clears it later.
  - SWEEP: each cycle entry[ptr] <= 0 and ptr <= ptr+1.
  - When ptr == DEPTH-1 the last entry is cleared, the FSM returns to IDLE and busy <= 0 at the same edge.
  - Busy is high for exactly DEPTH cycles.
  - clr_req during SWEEP is ignored and does not restart the sweep.
  - Writes during SWEEP are dropped.
  - Reads during SWEEP are allowed and return current contents: already-cleared entries read 0, pending entries read old data.
- Reset mid-sweep: the sweep aborts and reset behaviour applies; the next cycle is IDLE with busy=0.
- Simultaneous events: reset > sweep clear > write for the same entry. A dropped write has no side effect.

Optional Feature:
- Macro: TC_REGFILE_BYPASS_EN.
- Defined: if a write is accepted in cycle t with wr_addr == rdN_addr and rdN_en=1, then rdN_data at t+1 = wr_data (write-through forwarding, per port).
- Undefined: rdN_data at t+1 = the old entry value.
- Forwarding never applies to dropped writes (busy, out-of-range or reset).

Decomposition:
- Package tc_regfile_pkg holds:
  - the FSM state enum (TC_RF_IDLE, TC_RF_SWEEP);
  - a clog2-safe address-width function, returning minimum 1.
- Sub-module tc_regfile_read_port, instantiated twice. It contains:
  - the enable gating;
  - the range check;
  - the optional bypass mux;
  - the output register.

Test Plan (DATA_W=8, DEPTH=8 unless stated):
- Write/read: write 0x5A@3, next cycle rd0_en=1 addr 3 -> rd0_data=0x5A one cycle later. Same with rd0_en=0 -> rd0_data=0x00.
- Dual read: entry2=0x11, entry5=0x22; rd0 addr 2 and rd1 addr 5 in the same cycle -> 0x11 and 0x22 next cycle.
- Same-cycle read/write to addr 4 (old 0x10, new 0x99):
  - with TC_REGFILE_BYPASS_EN -> 0x99;
  - without -> 0x10;
  - read the following cycle -> 0x99 in both builds.
- Clear sweep:
  - fill 0x01..0x08, pulse clr_req -> busy high exactly 8 cycles;
  - write of 0xFF@0 during busy is dropped;
  - reading addr 7 on the 3rd busy cycle -> 0x08;
  - after busy falls, every address reads 0.
- Reset mid-sweep: assert reset on the 4th busy cycle -> next cycle busy=0, all entries 0, rd outputs 0.
- DEPTH=6: write 0x77@7 is dropped; read addr 7 -> 0; read addr 5 is unaffected.

Source files
------------

// File: rtl/tc_regfile_pkg.sv
// Shared types and helpers for the TC register file.
// Build option: define TC_REGFILE_BYPASS_EN for write-through read forwarding.
package tc_regfile_pkg;

  typedef enum logic {
    TC_RF_IDLE  = 1'b0,
    TC_RF_SWEEP = 1'b1
  } tc_rf_state_e;

  // $clog2 returns 0 for depth 1; ports still need at least one address bit.
  function automatic int tc_rf_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tc_regfile_read_port.sv
// One registered read port: range check, optional write-through, enable gating.
// Build option: TC_REGFILE_BYPASS_EN enables same-cycle write forwarding.
module tc_regfile_read_port
  import tc_regfile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = tc_rf_addr_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic                         wr_fire,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            data
);

  logic              in_range;
  logic [DATA_W-1:0] word;

  assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);

  always_comb begin
    word = in_range ? mem[addr] : '0;
`ifdef TC_REGFILE_BYPASS_EN
    // wr_fire is already range-checked and cleared for dropped writes.
    if (wr_fire && (wr_addr == addr)) word = wr_data;
`endif
  end

`ifndef TC_REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_fire, wr_addr, wr_data};
`endif

  always_ff @(posedge clk) begin
    if (reset) data <= '0;
    else       data <= en ? word : '0;
  end

endmodule

// File: rtl/tc_register_file.sv
// DEPTH x DATA_W register bank: two registered read ports, one write port, clear sweep.
// Build option: TC_REGFILE_BYPASS_EN forwards accepted writes to same-address reads.
module tc_register_file
  import tc_regfile_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = tc_rf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  tc_rf_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]            ptr_q, ptr_d;
  logic                         wr_fire;

  assign busy    = (state_q == TC_RF_SWEEP);
  assign wr_fire = wr_en & ~busy & ~reset & ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TC_RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      TC_RF_IDLE: begin
        if (clr_req) begin
          state_d = TC_RF_SWEEP;
          ptr_d   = '0;
        end
      end
      TC_RF_SWEEP: begin
        if (ptr_q == LAST) begin
          state_d = TC_RF_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = TC_RF_IDLE;
    endcase
  end

  // Writes are only accepted while idle, so the sweep never collides with one.
  always_ff @(posedge clk) begin
    if (reset)        mem <= '0;
    else if (busy)    mem[ptr_q] <= '0;
    else if (wr_fire) mem[wr_addr] <= wr_data;
  end

  logic [1:0]             rd_en;
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_en   = {rd1_en, rd0_en};
  assign rd_addr = {rd1_addr, rd0_addr};
  assign rd0_data = rd_data[0];
  assign rd1_data = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    tc_regfile_read_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .en      (rd_en[p]),
      .addr    (rd_addr[p]),
      .mem     (mem),
      .wr_fire (wr_fire),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[p])
    );
  end

endmodule

// File: tb/tb_tc_register_file.sv
// Directed self-checking bench for tc_register_file (DEPTH=8 and DEPTH=6 instances).
module tb_tc_register_file;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd0_en, rd1_en, wr_en, clr_req;
  logic [2:0] rd0_addr, rd1_addr, wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd0_data, rd1_data, rd0_data6, rd1_data6;
  logic       busy, busy6;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TC_REGFILE_BYPASS_EN
  localparam logic [7:0] SAME_EXP = 8'h99;
`else
  localparam logic [7:0] SAME_EXP = 8'h10;
`endif

  always #5 clk = ~clk;

  tc_register_file #(.DATA_W(8), .DEPTH(8)) u8 (
    .clk(clk), .reset(reset),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy)
  );

  tc_register_file #(.DATA_W(8), .DEPTH(6)) u6 (
    .clk(clk), .reset(reset),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data6),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data6),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy6)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rd0_en = 0; rd1_en = 0; wr_en = 0; clr_req = 0;
    rd0_addr = 0; rd1_addr = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic test_reset;
    reset = 1; idle_inputs();
    tick(); tick();
    n_checks++; if (rd0_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd0: got %h want 00", rd0_data); end
    n_checks++; if (rd1_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd1: got %h want 00", rd1_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (busy6 !== 1'b0) begin n_fail++; $display("FAIL reset_busy6: got %b want 0", busy6); end
    reset = 0;
    rd0_en = 1; rd0_addr = 0; rd1_en = 1; rd1_addr = 7;
    tick();
    n_checks++; if (rd0_data !== 8'h00 || rd1_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_entries: got %h/%h want 00/00", rd0_data, rd1_data);
    end
    idle_inputs();
  endtask

  task automatic test_write_read;
    wr_en = 1; wr_addr = 3; wr_data = 8'h5A;
    tick();
    wr_en = 0; rd0_en = 1; rd0_addr = 3;
    tick();
    n_checks++; if (rd0_data !== 8'h5A) begin n_fail++; $display("FAIL wr_rd: got %h want 5a", rd0_data); end
    rd0_en = 0;
    tick();
    n_checks++; if (rd0_data !== 8'h00) begin n_fail++; $display("FAIL rd_disabled: got %h want 00", rd0_data); end
    idle_inputs();
  endtask

  task automatic test_dual_read;
    wr_en = 1; wr_addr = 2; wr_data = 8'h11;
    tick();
    wr_addr = 5; wr_data = 8'h22;
    tick();
    wr_en = 0; rd0_en = 1; rd0_addr = 2; rd1_en = 1; rd1_addr = 5;
    tick();
    n_checks++; if (rd0_data !== 8'h11) begin n_fail++; $display("FAIL dual_rd0: got %h want 11", rd0_data); end
    n_checks++; if (rd1_data !== 8'h22) begin n_fail++; $display("FAIL dual_rd1: got %h want 22", rd1_data); end
    rd0_addr = 5; rd1_addr = 5;
    tick();
    n_checks++; if (rd0_data !== 8'h22 || rd1_data !== 8'h22) begin
      n_fail++; $display("FAIL dual_same_addr: got %h/%h want 22/22", rd0_data, rd1_data);
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle;
    wr_en = 1; wr_addr = 4; wr_data = 8'h10;
    tick();
    wr_data = 8'h99; rd0_en = 1; rd0_addr = 4; rd1_en = 1; rd1_addr = 4;
    tick();
    n_checks++; if (rd0_data !== SAME_EXP) begin n_fail++; $display("FAIL same_cycle_rd0: got %h want %h", rd0_data, SAME_EXP); end
    n_checks++; if (rd1_data !== SAME_EXP) begin n_fail++; $display("FAIL same_cycle_rd1: got %h want %h", rd1_data, SAME_EXP); end
    wr_en = 0;
    tick();
    n_checks++; if (rd0_data !== 8'h99) begin n_fail++; $display("FAIL after_write: got %h want 99", rd0_data); end
    idle_inputs();
  endtask

  task automatic test_clear;
    int busy_cycles;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 8'(i + 1);
      tick();
    end
    idle_inputs();
    clr_req = 1;
    tick();
    clr_req = 0;
    busy_cycles = 0;
    for (int c = 1; c <= 8; c++) begin
      if (busy === 1'b1) busy_cycles++;
      if (c == 2) begin wr_en = 1; wr_addr = 0; wr_data = 8'hFF; end
      if (c == 3) begin rd0_en = 1; rd0_addr = 0; rd1_en = 1; rd1_addr = 7; end
      if (c == 4) clr_req = 1;
      tick();
      idle_inputs();
      if (c == 3) begin
        n_checks++; if (rd1_data !== 8'h08) begin n_fail++; $display("FAIL sweep_pending: got %h want 08", rd1_data); end
        n_checks++; if (rd0_data !== 8'h00) begin n_fail++; $display("FAIL sweep_drop_wr: got %h want 00", rd0_data); end
      end
    end
    n_checks++; if (busy_cycles != 8) begin n_fail++; $display("FAIL busy_len: got %0d want 8", busy_cycles); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      rd0_en = 1; rd0_addr = 3'(i); rd1_en = 1; rd1_addr = 3'(i + 4);
      tick();
      n_checks++; if (rd0_data !== 8'h00 || rd1_data !== 8'h00) begin
        n_fail++; $display("FAIL cleared_%0d: got %h/%h want 00/00", i, rd0_data, rd1_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep;
    wr_en = 1; wr_addr = 6; wr_data = 8'hCD;
    tick();
    wr_addr = 1; wr_data = 8'hAB;
    tick();
    wr_en = 0;
    rd0_en = 1; rd0_addr = 6; rd1_en = 1; rd1_addr = 1;
    clr_req = 1;
    tick();
    clr_req = 0;
    tick(); tick(); tick();
    n_checks++; if (rd0_data !== 8'hCD || rd1_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_sweep_rd: got %h/%h want cd/00", rd0_data, rd1_data);
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_sweep_busy: got %b want 1", busy); end
    reset = 1;
    tick();
    reset = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (rd0_data !== 8'h00 || rd1_data !== 8'h00) begin
      n_fail++; $display("FAIL abort_rd: got %h/%h want 00/00", rd0_data, rd1_data);
    end
    tick();
    n_checks++; if (rd0_data !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_entry: got %h busy %b want 00 busy 0", rd0_data, busy);
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range;
    reset = 1;
    tick();
    reset = 0;
    wr_en = 1; wr_addr = 5; wr_data = 8'h55;
    tick();
    wr_addr = 7; wr_data = 8'h77;
    tick();
    wr_en = 0; rd0_en = 1; rd0_addr = 7; rd1_en = 1; rd1_addr = 5;
    tick();
    n_checks++; if (rd0_data6 !== 8'h00) begin n_fail++; $display("FAIL oob_rd: got %h want 00", rd0_data6); end
    n_checks++; if (rd1_data6 !== 8'h55) begin n_fail++; $display("FAIL oob_neighbor: got %h want 55", rd1_data6); end
    n_checks++; if (rd0_data !== 8'h77) begin n_fail++; $display("FAIL inrange_d8: got %h want 77", rd0_data); end
    wr_en = 1; wr_addr = 7; wr_data = 8'h66;
    tick();
    n_checks++; if (rd0_data6 !== 8'h00) begin n_fail++; $display("FAIL oob_bypass: got %h want 00", rd0_data6); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dual_read();
    test_same_cycle();
    test_clear();
    test_reset_mid_sweep();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
